// File: rtl/cordic_rr_scheduler.sv
// Round-robin scheduler time-sharing one iterative sine/cosine CORDIC engine among NREQ requesters.
// Job cadence: arbitrate (IDLE), start (ISSUE), wait for done or watchdog (WAIT), respond (RESP).
module cordic_rr_scheduler #(
  parameter int width   = 12,
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*width-1:0] angle_in,
  output logic                  cdc_start,
  output logic [width-1:0]      cdc_angle,
  input  logic                  cdc_done,
  input  logic [width-1:0]      cdc_sin,
  input  logic [width-1:0]      cdc_cos,
  output logic                  resp_valid,
  output logic [IDW-1:0]        resp_id,
  output logic [width-1:0]      SINout,
  output logic [width-1:0]      COSout,
  output logic                  resp_err,
  output logic                  busy
);

  localparam int               WDW     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WDW-1:0]   WD_LAST = WDW'(TIMEOUT - 1);
  localparam logic [IDW-1:0]   ID_LAST = IDW'(NREQ - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [IDW-1:0]   resp_id_q, resp_id_d;
  logic [width-1:0] angle_q, angle_d;
  logic [width-1:0] sin_q, sin_d;
  logic [width-1:0] cos_q, cos_d;
  logic [WDW-1:0]   wd_q, wd_d;
  logic             err_q, err_d;

  logic             gnt_vld;
  logic [IDW-1:0]   gnt_id;
  logic [width-1:0] gnt_angle;
  int               idx;

  // Rotating-priority search: first requester at or above ptr, wrapping.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    idx     = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!gnt_vld && req[idx]) begin
        gnt_vld = 1'b1;
        gnt_id  = IDW'(idx);
      end
    end
  end

  always_comb begin
    gnt_angle = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (gnt_id == IDW'(k)) gnt_angle = angle_in[k*width +: width];
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    resp_id_d = resp_id_q;
    angle_d   = angle_q;
    sin_d     = sin_q;
    cos_d     = cos_q;
    wd_d      = wd_q;
    err_d     = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (gnt_vld) begin
          id_d    = gnt_id;
          angle_d = gnt_angle;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        wd_d    = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        wd_d = wd_q + 1'b1;
        // A done arriving on the last watchdog cycle still counts as a good result.
        if (cdc_done) begin
          sin_d     = cdc_sin;
          cos_d     = cdc_cos;
          err_d     = 1'b0;
          resp_id_d = id_q;
          state_d   = S_RESP;
        end else if (wd_q == WD_LAST) begin
          sin_d     = '0;
          cos_d     = '0;
          err_d     = 1'b1;
          resp_id_d = id_q;
          state_d   = S_RESP;
        end
      end
      S_RESP: begin
        ptr_d   = (id_q == ID_LAST) ? '0 : id_q + 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      id_q      <= '0;
      resp_id_q <= '0;
      angle_q   <= '0;
      sin_q     <= '0;
      cos_q     <= '0;
      wd_q      <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      id_q      <= id_d;
      resp_id_q <= resp_id_d;
      angle_q   <= angle_d;
      sin_q     <= sin_d;
      cos_q     <= cos_d;
      wd_q      <= wd_d;
      err_q     <= err_d;
    end
  end

  assign cdc_start  = (state_q == S_ISSUE);
  assign resp_valid = (state_q == S_RESP);
  assign busy       = (state_q != S_IDLE);
  assign cdc_angle  = angle_q;
  assign resp_id    = resp_id_q;
  assign SINout     = sin_q;
  assign COSout     = cos_q;
  assign resp_err   = err_q;

endmodule
